wb_stage: RTL and testbench
===========================

# wb_stage

Writeback stage of the five-stage MIPS pipeline. Latches the memory stage's result into the MEM/WB pipeline register, honouring stall and flush. On the following edge it commits the result into the 32×32 general-purpose register file and the HI/LO pair. Supplies the decode stage with two combinational read ports and two HI/LO read outputs, all with write-through bypass.

## Interface
Parameters:
- `REG_NUM`, 32, number of GPRs; address width is log2(`REG_NUM`) = 5.
- `DATA_W`, 32, GPR/HI/LO data width.

Ports:
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `wreg_i`  in  1  MEM result writes a GPR.
- `waddr_i`  in  5  MEM destination GPR.
- `wdata_i`  in  32  MEM result data.
- `whilo_i`  in  1  MEM result writes HI/LO.
- `hi_i`, `lo_i`  in  32 each  HI/LO values from MEM.
- `stall_mem`  in  1  MEM stage is stalled this cycle.
- `stall_wb`  in  1  WB stage is stalled this cycle.
- `flush`  in  1  exception flush; squash the MEM result.
- `re1`, `re2`  in  1 each  read enables, ID ports 1/2.
- `raddr1`, `raddr2`  in  5 each  read addresses.
- `rdata1`, `rdata2`  out  32 each  read data (combinational).
- `hi_o`, `lo_o`  out  32 each  current HI/LO (combinational, bypassed).
- `wb_wreg_o`, `wb_waddr_o`, `wb_wdata_o`  out  1/5/32  registered MEM/WB GPR write, for forwarding and debug.

## Operation
- **MEM/WB register.** Fields: `wreg`, `waddr`, `wdata`, `whilo`, `hi`, `lo`. Update order on each edge, highest priority first:
  - `rst` or `flush`: clear all fields to 0.
  - `stall_mem`=1 and `stall_wb`=0: load a bubble (all fields 0).
  - `stall_mem`=0: load the `*_i` inputs.
  - otherwise: hold.
- **GPR write.** On each edge with `rst`=0, if `wreg`=1 and `waddr`≠0, `gpr[waddr]` ← `wdata`. GPR writes are not gated by stall; the MEM/WB register already holds a bubble or a stable value.
- **HI/LO write.** On each edge with `rst`=0, if `whilo`=1, HI ← `hi` and LO ← `lo`, simultaneously.
- **Reset.** Clears all 32 GPRs, HI, LO, and the MEM/WB register to 0.
- **GPR 0.** Reads as 0 at all times. Writes to it are discarded, and it is never a bypass source.
- **Read port n (n = 1, 2), combinational, priority order:**
  - `rst`=1: 0.
  - `re_n`=0: 0.
  - `raddr_n`=0: 0.
  - `wreg`=1 and `waddr`=`raddr_n`: `wdata` (bypass).
  - otherwise: `gpr[raddr_n]`.
- **HI/LO read.** `rst`=1 → 0. `whilo`=1 → `hi`/`lo` from the MEM/WB register. Otherwise → the architectural HI/LO.
- **Registered outputs.** `wb_*_o` are direct copies of the MEM/WB register fields.
- **Address width.** 5-bit addresses cover all 32 entries; there is no out-of-range case.

## Timing
- **Latency.** MEM result at edge N enters MEM/WB. It is visible on read ports (bypass) during cycle N→N+1, and is architectural after edge N+1. Read-after-write to the same address therefore has zero stall cycles.
- **Reset outputs.** While `rst`=1, every output is 0. The state is all-zero after the first edge with `rst`=1.
- **Reset mid-operation.** Any pending MEM/WB write is dropped, not committed.
- **Flush with stall.** `flush` overrides both stalls.
- **Both stalls high.** MEM/WB holds. The held write re-commits each cycle, which is idempotent.
- **Simultaneous access.** Both read ports may read the address being written; both receive the bypass value. HI/LO write and GPR write in the same cycle are independent.

## Test plan
- **Reset:** assert `rst` 2 cycles with `wreg_i`=1, `waddr_i`=5, `wdata_i`=0xDEADBEEF → all outputs 0. After release, `re1`=1, `raddr1`=5 reads 0.
- **Write then bypass:** `wreg_i`=1, `waddr_i`=3, `wdata_i`=0x12345678 for one edge, `re1`=1, `raddr1`=3:
  - next cycle `rdata1`=0x12345678 via bypass;
  - after another edge with `wreg_i`=0, still 0x12345678 from the GPR.
- **GPR 0:** write `waddr_i`=0, `wdata_i`=0xFFFFFFFF → `rdata1`/`rdata2` with address 0 read 0 in every cycle.
- **Stall bubble:** load `waddr_i`=7, `wdata_i`=0xA5, then `stall_mem`=1, `stall_wb`=0 with `waddr_i`=8, `wdata_i`=0xB6 → `wb_wreg_o`=0 next cycle. GPR7=0xA5 and GPR8 is unchanged.
- **Stall hold, then flush:** with `stall_mem`=`stall_wb`=1, `wb_*_o` stay constant for 3 cycles. Then `flush`=1 with `stall_mem`=1 → `wb_wreg_o`=0 and `wb_whilo`=0 after the edge.
- **HI/LO:** `whilo_i`=1, `hi_i`=0x1, `lo_i`=0x2 → `hi_o`/`lo_o`=0x1/0x2 one cycle after the edge (bypass), and retained after `whilo_i` drops. Then `rst`=1 → both read 0.

Source files
------------

// File: rtl/wb_stage_if.sv
// MEM-to-WB result bus plus the decode-stage register read ports of the writeback stage.
interface wb_stage_if #(
  parameter int REG_NUM = 32,
  parameter int DATA_W  = 32
);
  localparam int AW = $clog2(REG_NUM);

  logic              wreg_i;
  logic [AW-1:0]     waddr_i;
  logic [DATA_W-1:0] wdata_i;
  logic              whilo_i;
  logic [DATA_W-1:0] hi_i;
  logic [DATA_W-1:0] lo_i;
  logic              stall_mem;
  logic              stall_wb;
  logic              flush;
  logic              re1;
  logic              re2;
  logic [AW-1:0]     raddr1;
  logic [AW-1:0]     raddr2;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;
  logic              wb_wreg_o;
  logic [AW-1:0]     wb_waddr_o;
  logic [DATA_W-1:0] wb_wdata_o;

  modport master (
    output wreg_i, waddr_i, wdata_i, whilo_i, hi_i, lo_i,
    output stall_mem, stall_wb, flush,
    output re1, re2, raddr1, raddr2,
    input  rdata1, rdata2, hi_o, lo_o,
    input  wb_wreg_o, wb_waddr_o, wb_wdata_o
  );

  modport slave (
    input  wreg_i, waddr_i, wdata_i, whilo_i, hi_i, lo_i,
    input  stall_mem, stall_wb, flush,
    input  re1, re2, raddr1, raddr2,
    output rdata1, rdata2, hi_o, lo_o,
    output wb_wreg_o, wb_waddr_o, wb_wdata_o
  );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB pipeline register, GPR file and HI/LO commit,
// with write-through bypass on the decode-stage read ports.
module wb_stage #(
  parameter int REG_NUM = 32,
  parameter int DATA_W  = 32
) (
  input logic       clk,
  input logic       rst,
  wb_stage_if.slave bus
);
  localparam int AW = $clog2(REG_NUM);

  logic              wb_wreg;
  logic [AW-1:0]     wb_waddr;
  logic [DATA_W-1:0] wb_wdata;
  logic              wb_whilo;
  logic [DATA_W-1:0] wb_hi;
  logic [DATA_W-1:0] wb_lo;

  logic [DATA_W-1:0] gpr [REG_NUM];
  logic [DATA_W-1:0] hi_arch;
  logic [DATA_W-1:0] lo_arch;

  // Flush beats both stalls; a stalled MEM with a running WB leaves a bubble.
  always_ff @(posedge clk) begin
    if (rst || bus.flush || (bus.stall_mem && !bus.stall_wb)) begin
      wb_wreg  <= 1'b0;
      wb_waddr <= '0;
      wb_wdata <= '0;
      wb_whilo <= 1'b0;
      wb_hi    <= '0;
      wb_lo    <= '0;
    end else if (!bus.stall_mem) begin
      wb_wreg  <= bus.wreg_i;
      wb_waddr <= bus.waddr_i;
      wb_wdata <= bus.wdata_i;
      wb_whilo <= bus.whilo_i;
      wb_hi    <= bus.hi_i;
      wb_lo    <= bus.lo_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        gpr[i] <= '0;
      end
    end else if (wb_wreg && (wb_waddr != '0)) begin
      gpr[wb_waddr] <= wb_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_arch <= '0;
      lo_arch <= '0;
    end else if (wb_whilo) begin
      hi_arch <= wb_hi;
      lo_arch <= wb_lo;
    end
  end

  // Register 0 is never a bypass source: the address check comes first.
  always_comb begin
    bus.rdata1 = '0;
    if (!rst && bus.re1 && (bus.raddr1 != '0)) begin
      if (wb_wreg && (wb_waddr == bus.raddr1)) bus.rdata1 = wb_wdata;
      else                                     bus.rdata1 = gpr[bus.raddr1];
    end
  end

  always_comb begin
    bus.rdata2 = '0;
    if (!rst && bus.re2 && (bus.raddr2 != '0)) begin
      if (wb_wreg && (wb_waddr == bus.raddr2)) bus.rdata2 = wb_wdata;
      else                                     bus.rdata2 = gpr[bus.raddr2];
    end
  end

  always_comb begin
    bus.hi_o = '0;
    bus.lo_o = '0;
    if (!rst) begin
      bus.hi_o = wb_whilo ? wb_hi : hi_arch;
      bus.lo_o = wb_whilo ? wb_lo : lo_arch;
    end
  end

  assign bus.wb_wreg_o  = rst ? 1'b0 : wb_wreg;
  assign bus.wb_waddr_o = rst ? '0   : wb_waddr;
  assign bus.wb_wdata_o = rst ? '0   : wb_wdata;
endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios plus a randomized run against a
// behavioural model of the register file, HI/LO and the pending writeback.
module tb_wb_stage;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  wb_stage_if #(.REG_NUM(32), .DATA_W(32)) b ();
  wb_stage #(.REG_NUM(32), .DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(b));

  // Model: architectural state plus the one result waiting to commit.
  logic [31:0] m_gpr [32];
  logic [31:0] m_hi, m_lo;
  logic        p_wreg, p_whilo;
  logic [4:0]  p_waddr;
  logic [31:0] p_wdata, p_hi, p_lo;

  task automatic clear_pending();
    p_wreg = 0; p_waddr = 0; p_wdata = 0; p_whilo = 0; p_hi = 0; p_lo = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      foreach (m_gpr[i]) m_gpr[i] = 0;
      m_hi = 0; m_lo = 0;
      clear_pending();
    end else begin
      if (p_wreg && p_waddr != 0) m_gpr[p_waddr] = p_wdata;
      if (p_whilo) begin m_hi = p_hi; m_lo = p_lo; end
      if (b.flush || (b.stall_mem && !b.stall_wb)) clear_pending();
      else if (!b.stall_mem) begin
        p_wreg = b.wreg_i; p_waddr = b.waddr_i; p_wdata = b.wdata_i;
        p_whilo = b.whilo_i; p_hi = b.hi_i; p_lo = b.lo_i;
      end
    end
    #1;
  endtask

  function automatic logic [31:0] exp_rd(input logic re, input logic [4:0] a);
    if (rst || !re || a == 0) return 32'h0;
    if (p_wreg && p_waddr == a) return p_wdata;
    return m_gpr[a];
  endfunction

  task automatic idle_inputs();
    b.wreg_i = 0; b.waddr_i = 0; b.wdata_i = 0; b.whilo_i = 0; b.hi_i = 0; b.lo_i = 0;
    b.stall_mem = 0; b.stall_wb = 0; b.flush = 0;
    b.re1 = 0; b.re2 = 0; b.raddr1 = 0; b.raddr2 = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    b.wreg_i = 1; b.waddr_i = 5; b.wdata_i = 32'hDEADBEEF;
    b.whilo_i = 1; b.hi_i = 32'h11; b.lo_i = 32'h22;
    b.re1 = 1; b.raddr1 = 5; b.re2 = 1; b.raddr2 = 5;
    repeat (2) tick();
    checks++;
    if ({b.rdata1, b.rdata2, b.hi_o, b.lo_o, b.wb_wreg_o, b.wb_waddr_o, b.wb_wdata_o} !== '0) begin
      failures++;
      $display("FAIL reset_outputs rdata1=%h rdata2=%h hi=%h lo=%h wb_wreg=%b wb_waddr=%0d wb_wdata=%h expected all 0",
               b.rdata1, b.rdata2, b.hi_o, b.lo_o, b.wb_wreg_o, b.wb_waddr_o, b.wb_wdata_o);
    end
    b.wreg_i = 0; b.whilo_i = 0;
    rst = 0;
    tick();
    checks++;
    if (b.rdata1 !== 32'h0) begin
      failures++; $display("FAIL reset_gpr5 got=%h exp=00000000", b.rdata1);
    end
  endtask

  task automatic test_bypass();
    b.wreg_i = 1; b.waddr_i = 3; b.wdata_i = 32'h12345678;
    b.re1 = 1; b.raddr1 = 3;
    tick();
    checks++;
    if (b.rdata1 !== 32'h12345678 || b.wb_waddr_o !== 5'd3 || b.wb_wreg_o !== 1'b1) begin
      failures++; $display("FAIL bypass_read rdata1=%h wb_waddr=%0d wb_wreg=%b exp 12345678/3/1",
                           b.rdata1, b.wb_waddr_o, b.wb_wreg_o);
    end
    b.wreg_i = 0;
    tick();
    checks++;
    if (b.rdata1 !== 32'h12345678 || b.wb_wreg_o !== 1'b0) begin
      failures++; $display("FAIL bypass_committed rdata1=%h wb_wreg=%b exp 12345678/0", b.rdata1, b.wb_wreg_o);
    end
  endtask

  task automatic test_gpr0();
    b.wreg_i = 1; b.waddr_i = 0; b.wdata_i = 32'hFFFFFFFF;
    b.re1 = 1; b.raddr1 = 0; b.re2 = 1; b.raddr2 = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (b.rdata1 !== 32'h0 || b.rdata2 !== 32'h0) begin
        failures++; $display("FAIL gpr0_read cycle=%0d rdata1=%h rdata2=%h exp 0/0", i, b.rdata1, b.rdata2);
      end
      b.wreg_i = (i == 0);
    end
    b.wreg_i = 0;
  endtask

  task automatic test_stall_bubble();
    logic [31:0] old8;
    old8 = m_gpr[8];
    b.wreg_i = 1; b.waddr_i = 7; b.wdata_i = 32'hA5;
    tick();
    b.stall_mem = 1; b.stall_wb = 0; b.waddr_i = 8; b.wdata_i = 32'hB6;
    tick();
    checks++;
    if (b.wb_wreg_o !== 1'b0) begin
      failures++; $display("FAIL stall_bubble wb_wreg=%b exp 0", b.wb_wreg_o);
    end
    b.stall_mem = 0; b.wreg_i = 0;
    b.re1 = 1; b.raddr1 = 7; b.re2 = 1; b.raddr2 = 8;
    tick();
    checks++;
    if (b.rdata1 !== 32'hA5 || b.rdata2 !== old8) begin
      failures++; $display("FAIL stall_gprs gpr7=%h exp=000000a5 gpr8=%h exp=%h", b.rdata1, b.rdata2, old8);
    end
  endtask

  task automatic test_stall_hold_flush();
    b.wreg_i = 1; b.waddr_i = 9; b.wdata_i = 32'h99;
    b.whilo_i = 1; b.hi_i = 32'h3; b.lo_i = 32'h4;
    tick();
    b.stall_mem = 1; b.stall_wb = 1;
    b.waddr_i = 10; b.wdata_i = 32'h1010; b.hi_i = 32'h55; b.lo_i = 32'h66;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (b.wb_wreg_o !== 1'b1 || b.wb_waddr_o !== 5'd9 || b.wb_wdata_o !== 32'h99 || b.hi_o !== 32'h3) begin
        failures++; $display("FAIL stall_hold cycle=%0d wreg=%b waddr=%0d wdata=%h hi=%h exp 1/9/00000099/00000003",
                             i, b.wb_wreg_o, b.wb_waddr_o, b.wb_wdata_o, b.hi_o);
      end
    end
    b.flush = 1;
    tick();
    checks++;
    if (b.wb_wreg_o !== 1'b0 || b.wb_wdata_o !== 32'h0 || b.hi_o !== 32'h3 || b.lo_o !== 32'h4) begin
      failures++; $display("FAIL flush_stall wreg=%b wdata=%h hi=%h lo=%h exp 0/0/3/4",
                           b.wb_wreg_o, b.wb_wdata_o, b.hi_o, b.lo_o);
    end
    idle_inputs();
    b.re1 = 1; b.raddr1 = 10;
    tick();
    checks++;
    if (b.rdata1 !== m_gpr[10]) begin
      failures++; $display("FAIL flush_no_commit gpr10=%h exp=%h", b.rdata1, m_gpr[10]);
    end
  endtask

  task automatic test_hilo();
    b.whilo_i = 1; b.hi_i = 32'h1; b.lo_i = 32'h2;
    tick();
    checks++;
    if (b.hi_o !== 32'h1 || b.lo_o !== 32'h2) begin
      failures++; $display("FAIL hilo_bypass hi=%h lo=%h exp 1/2", b.hi_o, b.lo_o);
    end
    b.whilo_i = 0;
    repeat (2) tick();
    checks++;
    if (b.hi_o !== 32'h1 || b.lo_o !== 32'h2) begin
      failures++; $display("FAIL hilo_retained hi=%h lo=%h exp 1/2", b.hi_o, b.lo_o);
    end
    rst = 1;
    #1;
    checks++;
    if (b.hi_o !== 32'h0 || b.lo_o !== 32'h0) begin
      failures++; $display("FAIL hilo_reset_comb hi=%h lo=%h exp 0/0", b.hi_o, b.lo_o);
    end
    tick();
    rst = 0;
    #1;
    checks++;
    if (b.hi_o !== 32'h0 || b.lo_o !== 32'h0) begin
      failures++; $display("FAIL hilo_reset_cleared hi=%h lo=%h exp 0/0", b.hi_o, b.lo_o);
    end
  endtask

  task automatic test_random();
    logic [31:0] e1, e2, eh, el;
    for (int n = 0; n < 400; n++) begin
      rst         = ($urandom_range(0, 63) == 0);
      b.wreg_i    = $urandom_range(0, 3) != 0;
      b.waddr_i   = 5'($urandom_range(0, 7));
      b.wdata_i   = $urandom;
      b.whilo_i   = $urandom_range(0, 2) == 0;
      b.hi_i      = $urandom;
      b.lo_i      = $urandom;
      b.stall_mem = $urandom_range(0, 3) == 0;
      b.stall_wb  = $urandom_range(0, 3) == 0;
      b.flush     = $urandom_range(0, 15) == 0;
      b.re1       = $urandom_range(0, 7) != 0;
      b.re2       = $urandom_range(0, 7) != 0;
      b.raddr1    = 5'($urandom_range(0, 7));
      b.raddr2    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : b.raddr1;
      tick();
      e1 = exp_rd(b.re1, b.raddr1);
      e2 = exp_rd(b.re2, b.raddr2);
      eh = rst ? 32'h0 : (p_whilo ? p_hi : m_hi);
      el = rst ? 32'h0 : (p_whilo ? p_lo : m_lo);
      checks++;
      if (b.rdata1 !== e1 || b.rdata2 !== e2) begin
        failures++; $display("FAIL rand_read n=%0d rdata1=%h exp=%h rdata2=%h exp=%h", n, b.rdata1, e1, b.rdata2, e2);
      end
      checks++;
      if (b.hi_o !== eh || b.lo_o !== el) begin
        failures++; $display("FAIL rand_hilo n=%0d hi=%h exp=%h lo=%h exp=%h", n, b.hi_o, eh, b.lo_o, el);
      end
      checks++;
      if (b.wb_wreg_o !== (rst ? 1'b0 : p_wreg) || b.wb_waddr_o !== (rst ? 5'd0 : p_waddr)
          || b.wb_wdata_o !== (rst ? 32'h0 : p_wdata)) begin
        failures++; $display("FAIL rand_memwb n=%0d wreg=%b waddr=%0d wdata=%h exp %b/%0d/%h",
                             n, b.wb_wreg_o, b.wb_waddr_o, b.wb_wdata_o, p_wreg, p_waddr, p_wdata);
      end
    end
    rst = 0;
    idle_inputs();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    foreach (m_gpr[i]) m_gpr[i] = 0;
    m_hi = 0; m_lo = 0;
    clear_pending();
    test_reset();
    idle_inputs();
    test_bypass();
    idle_inputs();
    test_gpr0();
    idle_inputs();
    test_stall_bubble();
    idle_inputs();
    test_stall_hold_flush();
    idle_inputs();
    test_hilo();
    idle_inputs();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
